// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 frame definitions; OUT_W widens to carry {ext, brk} when PS2_KEY_EVENT_EN is defined
package ps2_pkg;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;
   localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
   localparam int DATA_BITS = 8;
   localparam int CNT_W = $clog2(DATA_BITS);
`ifdef PS2_KEY_EVENT_EN
   localparam int OUT_W = DATA_BITS + 2;
`else
   localparam int OUT_W = DATA_BITS;
`endif
endpackage

// File: rtl/ps2_afifo.sv
// ps2_afifo: dual-clock FIFO, Gray pointers crossing through SYNC_STAGES-deep synchronisers
module ps2_afifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int SYNC_STAGES = 2,
   parameter int WIDTH = 8
) (
   input  logic             wr_clk,
   input  logic             rd_clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   input  logic             rd_en,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data
);
   localparam int PW = DEPTH_LOG2 + 1;
   localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);
   logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
   logic [PW-1:0] wbin, wgray, rbin, rgray, wbin_nxt, rbin_nxt;
   logic [SYNC_STAGES-1:0][PW-1:0] rsync, wsync;
   logic push, pop;
   assign full = (wgray ^ rsync[SYNC_STAGES-1]) == FULL_MASK;
   assign rd_valid = rgray != wsync[SYNC_STAGES-1];
   assign rd_data = mem[rbin[DEPTH_LOG2-1:0]];
   assign push = wr_en && !full;
   assign pop = rd_en && rd_valid;
   assign wbin_nxt = wbin + PW'(1);
   assign rbin_nxt = rbin + PW'(1);
   always_ff @(posedge wr_clk) if (push) mem[wbin[DEPTH_LOG2-1:0]] <= wr_data;
   always_ff @(posedge wr_clk)
      if (!rst_n) begin
         wbin <= '0;
         wgray <= '0;
         rsync <= '0;
      end else begin
         rsync <= {rsync[SYNC_STAGES-2:0], rgray};
         if (push) begin
            wbin <= wbin_nxt;
            wgray <= wbin_nxt ^ (wbin_nxt >> 1);
         end
      end
   always_ff @(posedge rd_clk)
      if (!rst_n) begin
         rbin <= '0;
         rgray <= '0;
         wsync <= '0;
      end else begin
         wsync <= {wsync[SYNC_STAGES-2:0], wgray};
         if (pop) begin
            rbin <= rbin_nxt;
            rgray <= rbin_nxt ^ (rbin_nxt >> 1);
         end
      end
endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 frame receiver feeding a dual-clock FIFO; PS2_KEY_EVENT_EN folds E0/F0 prefixes into {ext, brk, byte}
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CHECK_PARITY = 1
) (
   input  logic             ps2_clk,
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic             ps2_data,
   input  logic             rd_en,
   output logic             rd_valid,
   output logic [OUT_W-1:0] rd_data,
   output logic             overflow,
   output logic             parity_err,
   output logic             frame_err
);
   frame_state_t state;
   logic [CNT_W-1:0] cnt;
   logic [DATA_BITS-1:0] shift;
   logic par, par_ok, good, commit, push, full;
   logic [OUT_W-1:0] entry;
   assign par_ok = ^{shift, par};
   assign good = ps2_data && (par_ok || CHECK_PARITY == 0);
   assign commit = state == STOP && good;
`ifdef PS2_KEY_EVENT_EN
   logic ext, brk, prefix;
   assign prefix = shift == PS2_PREFIX_EXT || shift == PS2_PREFIX_BRK;
   assign push = commit && !prefix;
   assign entry = {ext, brk, shift};
   // Prefixes accumulate; any pushed byte or dropped frame clears both
   always_ff @(posedge ps2_clk)
      if (!rst_n) begin
         ext <= 1'b0;
         brk <= 1'b0;
      end else if (state == STOP) begin
         ext <= commit && (shift == PS2_PREFIX_EXT || (prefix && ext));
         brk <= commit && (shift == PS2_PREFIX_BRK || (prefix && brk));
      end
`else
   assign push = commit;
   assign entry = shift;
`endif
   always_ff @(posedge ps2_clk)
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         shift <= '0;
         par <= 1'b0;
         overflow <= 1'b0;
         parity_err <= 1'b0;
         frame_err <= 1'b0;
      end else
         case (state)
            IDLE: begin
               cnt <= '0;
               if (!ps2_data) state <= DATA;
            end
            DATA: begin
               shift <= {ps2_data, shift[DATA_BITS-1:1]};
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(DATA_BITS - 1)) state <= PARITY;
            end
            PARITY: begin
               par <= ps2_data;
               state <= STOP;
            end
            default: begin
               state <= IDLE;
               if (!ps2_data) frame_err <= 1'b1;
               else if (CHECK_PARITY != 0 && !par_ok) parity_err <= 1'b1;
               if (push && full) overflow <= 1'b1;
            end
         endcase
   ps2_afifo #(
      .DEPTH_LOG2(DEPTH_LOG2),
      .SYNC_STAGES(SYNC_STAGES),
      .WIDTH(OUT_W)
   ) u_fifo (
      .wr_clk(ps2_clk),
      .rd_clk(sys_clk),
      .rst_n(rst_n),
      .wr_en(push),
      .wr_data(entry),
      .full(full),
      .rd_en(rd_en),
      .rd_valid(rd_valid),
      .rd_data(rd_data)
   );
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: two receivers (parity checked / ignored) on one PS/2 line, compared with a queue-based model
`timescale 1ns/1ps
module tb_ps2_rx_fifo;
`ifdef PS2_KEY_EVENT_EN
   localparam int W = 10;
`else
   localparam int W = 8;
`endif
   logic ps2_clk = 1'b0, sys_clk = 1'b0, rst_n = 1'b0, ps2_data = 1'b1;
   logic rd_en0 = 1'b0, rd_en1 = 1'b0;
   logic rd_valid0, rd_valid1, overflow0, overflow1, parity_err0, parity_err1, frame_err0, frame_err1;
   logic [W-1:0] rd_data0, rd_data1;
   int n_cmp = 0, n_bad = 0;
   logic [W-1:0] q0[$], q1[$];
   bit m_ovf[2], m_perr[2], m_ferr[2], m_ext[2], m_brk[2];

   always #50 ps2_clk = ~ps2_clk;
   always #5 sys_clk = ~sys_clk;

   ps2_rx_fifo #(.DEPTH_LOG2(4), .SYNC_STAGES(2), .CHECK_PARITY(1)) u_dut (
      .ps2_clk(ps2_clk), .sys_clk(sys_clk), .rst_n(rst_n), .ps2_data(ps2_data), .rd_en(rd_en0),
      .rd_valid(rd_valid0), .rd_data(rd_data0), .overflow(overflow0), .parity_err(parity_err0),
      .frame_err(frame_err0));
   ps2_rx_fifo #(.DEPTH_LOG2(4), .SYNC_STAGES(2), .CHECK_PARITY(0)) u_np (
      .ps2_clk(ps2_clk), .sys_clk(sys_clk), .rst_n(rst_n), .ps2_data(ps2_data), .rd_en(rd_en1),
      .rd_valid(rd_valid1), .rd_data(rd_data1), .overflow(overflow1), .parity_err(parity_err1),
      .frame_err(frame_err1));

   // Model: what one finished frame does to instance i (0 checks parity, 1 ignores it)
   task automatic model_frame(input int i, input logic [7:0] b, input bit p, input bit s);
      bit pok, good;
      logic [W-1:0] e;
      pok = ^{b, p};
      good = s && (pok || i == 1);
      if (!s) m_ferr[i] = 1;
      else if (i == 0 && !pok) m_perr[i] = 1;
      if (!good) begin
         m_ext[i] = 0;
         m_brk[i] = 0;
         return;
      end
`ifdef PS2_KEY_EVENT_EN
      if (b == 8'hE0) begin m_ext[i] = 1; return; end
      if (b == 8'hF0) begin m_brk[i] = 1; return; end
      e = {m_ext[i], m_brk[i], b};
      m_ext[i] = 0;
      m_brk[i] = 0;
`else
      e = b;
`endif
      if (i == 0) begin
         if (q0.size() == 16) m_ovf[0] = 1; else q0.push_back(e);
      end else begin
         if (q1.size() == 16) m_ovf[1] = 1; else q1.push_back(e);
      end
   endtask

   function automatic logic [W-1:0] mpop(input int i);
      return (i == 0) ? q0.pop_front() : q1.pop_front();
   endfunction

   function automatic int msize(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   task automatic model_clear;
      q0.delete();
      q1.delete();
      for (int i = 0; i < 2; i++) begin
         m_ovf[i] = 0; m_perr[i] = 0; m_ferr[i] = 0; m_ext[i] = 0; m_brk[i] = 0;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit p, input bit s);
      @(negedge ps2_clk) ps2_data = 1'b0;
      for (int k = 0; k < 8; k++) begin @(negedge ps2_clk); ps2_data = b[k]; end
      @(negedge ps2_clk) ps2_data = p;
      @(negedge ps2_clk) ps2_data = s;
      @(posedge ps2_clk); #1;
      ps2_data = 1'b1;
      model_frame(0, b, p, s);
      model_frame(1, b, p, s);
   endtask

   task automatic good_frame(input logic [7:0] b);
      send_frame(b, ~(^b), 1'b1);
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      ps2_data = 1'b1;
      repeat (2) @(posedge ps2_clk);
      #1 rst_n = 1'b1;
      model_clear();
   endtask

   task automatic settle;
      repeat (4) @(posedge sys_clk);
      @(negedge sys_clk);
   endtask

   task automatic pop_one(input int i, output bit v, output logic [W-1:0] d);
      @(negedge sys_clk);
      v = (i == 0) ? rd_valid0 : rd_valid1;
      d = (i == 0) ? rd_data0 : rd_data1;
      if (i == 0) rd_en0 = v; else rd_en1 = v;
      @(negedge sys_clk);
      rd_en0 = 1'b0;
      rd_en1 = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      @(negedge sys_clk);
      n_cmp++; if (rd_valid0 !== 1'b0) begin n_bad++; $display("FAIL reset_valid0: got %b want 0", rd_valid0); end
      n_cmp++; if (rd_valid1 !== 1'b0) begin n_bad++; $display("FAIL reset_valid1: got %b want 0", rd_valid1); end
      n_cmp++; if ({overflow0, parity_err0, frame_err0} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {overflow0, parity_err0, frame_err0}); end
   endtask

   task automatic test_good;
      bit v;
      logic [W-1:0] d;
      send_frame(8'h1C, 1'b0, 1'b1);
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      n_cmp++; if (rd_valid0 !== 1'b1) begin n_bad++; $display("FAIL good_valid: got %b want 1", rd_valid0); end
      n_cmp++; if (rd_data0 !== W'(10'h01C)) begin n_bad++; $display("FAIL good_data: got %h want %h", rd_data0, W'(10'h01C)); end
      n_cmp++; if ({overflow0, parity_err0, frame_err0} !== 3'b000) begin n_bad++; $display("FAIL good_flags: got %b want 000", {overflow0, parity_err0, frame_err0}); end
      pop_one(0, v, d); void'(mpop(0));
      pop_one(1, v, d); void'(mpop(1));
      @(negedge sys_clk);
      n_cmp++; if (rd_valid0 !== 1'b0) begin n_bad++; $display("FAIL good_empty: got %b want 0", rd_valid0); end
   endtask

   task automatic test_parity;
      bit v;
      logic [W-1:0] d;
      send_frame(8'h1C, 1'b1, 1'b1);
      settle();
      n_cmp++; if (rd_valid0 !== 1'b0) begin n_bad++; $display("FAIL par_dropped: got %b want 0", rd_valid0); end
      n_cmp++; if (parity_err0 !== 1'b1) begin n_bad++; $display("FAIL par_err: got %b want 1", parity_err0); end
      n_cmp++; if (rd_valid1 !== 1'b1 || rd_data1 !== W'(10'h01C)) begin n_bad++; $display("FAIL par_ignored_entry: got %b/%h want 1/%h", rd_valid1, rd_data1, W'(10'h01C)); end
      n_cmp++; if (parity_err1 !== 1'b0) begin n_bad++; $display("FAIL par_ignored_flag: got %b want 0", parity_err1); end
      pop_one(1, v, d); void'(mpop(1));
   endtask

   task automatic test_frame_err;
      bit v;
      logic [W-1:0] d;
      send_frame(8'h1C, 1'b0, 1'b0);
      good_frame(8'h32);
      settle();
      n_cmp++; if (frame_err0 !== 1'b1 || frame_err1 !== 1'b1) begin n_bad++; $display("FAIL frame_err: got %b%b want 11", frame_err0, frame_err1); end
      n_cmp++; if (rd_valid0 !== 1'b1 || rd_data0 !== W'(10'h032)) begin n_bad++; $display("FAIL frame_next: got %b/%h want 1/%h", rd_valid0, rd_data0, W'(10'h032)); end
      n_cmp++; if (rd_data1 !== W'(10'h032)) begin n_bad++; $display("FAIL frame_next_np: got %h want %h", rd_data1, W'(10'h032)); end
      pop_one(0, v, d); void'(mpop(0));
      pop_one(1, v, d); void'(mpop(1));
   endtask

   task automatic test_overflow;
      bit v;
      logic [W-1:0] d, e;
      for (int b = 0; b < 17; b++) good_frame(8'(b));
      settle();
      n_cmp++; if (overflow0 !== 1'b1 || overflow1 !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b%b want 11", overflow0, overflow1); end
      for (int i = 0; i < 2; i++)
         for (int k = 0; k < 16; k++) begin
            pop_one(i, v, d);
            e = (msize(i) > 0) ? mpop(i) : '0;
            n_cmp++; if (v !== 1'b1 || d !== W'(k) || e !== W'(k)) begin n_bad++; $display("FAIL ovf_pop%0d_%0d: got %b/%h want 1/%h", i, k, v, d, W'(k)); end
         end
      @(negedge sys_clk);
      n_cmp++; if (rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0) begin n_bad++; $display("FAIL ovf_empty: got %b%b want 00", rd_valid0, rd_valid1); end
   endtask

   task automatic test_mid_reset;
      bit v;
      logic [W-1:0] d;
      logic [7:0] b;
      b = 8'hA5;
      @(negedge ps2_clk) ps2_data = 1'b0;
      for (int k = 0; k < 5; k++) begin @(negedge ps2_clk); ps2_data = b[k]; end
      @(posedge ps2_clk); #1;
      do_reset();
      settle();
      n_cmp++; if (rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0) begin n_bad++; $display("FAIL midrst_nowrite: got %b%b want 00", rd_valid0, rd_valid1); end
      good_frame(8'h5A);
      settle();
      n_cmp++; if (rd_valid0 !== 1'b1 || rd_data0 !== W'(10'h05A)) begin n_bad++; $display("FAIL midrst_data: got %b/%h want 1/%h", rd_valid0, rd_data0, W'(10'h05A)); end
      n_cmp++; if ({overflow0, parity_err0, frame_err0, overflow1, parity_err1, frame_err1} !== 6'b0) begin n_bad++; $display("FAIL midrst_flags: got %b want 000000", {overflow0, parity_err0, frame_err0, overflow1, parity_err1, frame_err1}); end
      pop_one(0, v, d); void'(mpop(0));
      pop_one(1, v, d); void'(mpop(1));
   endtask

`ifdef PS2_KEY_EVENT_EN
   task automatic test_event;
      bit v;
      logic [W-1:0] d;
      good_frame(8'hE0);
      good_frame(8'hF0);
      good_frame(8'h75);
      settle();
      n_cmp++; if (rd_valid0 !== 1'b1 || rd_data0 !== W'(10'h375)) begin n_bad++; $display("FAIL evt_375: got %b/%h want 1/375", rd_valid0, rd_data0); end
      pop_one(0, v, d); void'(mpop(0));
      pop_one(1, v, d); void'(mpop(1));
      @(negedge sys_clk);
      n_cmp++; if (rd_valid0 !== 1'b0) begin n_bad++; $display("FAIL evt_single: got %b want 0", rd_valid0); end
      good_frame(8'h1C);
      settle();
      n_cmp++; if (rd_data0 !== W'(10'h01C)) begin n_bad++; $display("FAIL evt_01c: got %h want 01C", rd_data0); end
      pop_one(0, v, d); void'(mpop(0));
      pop_one(1, v, d); void'(mpop(1));
   endtask
`endif

   // Random frames (some with bad parity or stop) while both sides pop concurrently
   task automatic test_random;
      bit done, v;
      logic [W-1:0] d, e;
      done = 0;
      fork
         begin
            for (int n = 0; n < 40; n++) begin
               logic [7:0] b;
               int r;
               b = 8'($urandom);
               r = int'($urandom_range(0, 9));
               send_frame(b, ~(^b) ^ (r == 0), r != 1);
               repeat ($urandom_range(0, 2)) @(negedge ps2_clk);
            end
            done = 1;
         end
         begin
            while (!done) begin
               @(negedge sys_clk);
               if (rd_valid0) begin
                  n_cmp++;
                  if (q0.size() == 0 || rd_data0 !== q0[0]) begin n_bad++; $display("FAIL rnd_head0: got %h want %h (model size %0d)", rd_data0, (q0.size() > 0) ? q0[0] : '0, q0.size()); end
               end
               if (rd_valid1) begin
                  n_cmp++;
                  if (q1.size() == 0 || rd_data1 !== q1[0]) begin n_bad++; $display("FAIL rnd_head1: got %h want %h (model size %0d)", rd_data1, (q1.size() > 0) ? q1[0] : '0, q1.size()); end
               end
               rd_en0 = rd_valid0 && q0.size() > 0 && $urandom_range(0, 7) == 0;
               rd_en1 = rd_valid1 && q1.size() > 0 && $urandom_range(0, 7) == 0;
               if (rd_en0) void'(mpop(0));
               if (rd_en1) void'(mpop(1));
            end
            rd_en0 = 1'b0;
            rd_en1 = 1'b0;
         end
      join
      settle();
      for (int i = 0; i < 2; i++)
         while (msize(i) > 0) begin
            e = mpop(i);
            pop_one(i, v, d);
            n_cmp++; if (v !== 1'b1 || d !== e) begin n_bad++; $display("FAIL rnd_drain%0d: got %b/%h want 1/%h", i, v, d, e); end
         end
      @(negedge sys_clk);
      n_cmp++; if (rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0) begin n_bad++; $display("FAIL rnd_empty: got %b%b want 00", rd_valid0, rd_valid1); end
      n_cmp++; if ({overflow0, parity_err0, frame_err0} !== {m_ovf[0], m_perr[0], m_ferr[0]}) begin n_bad++; $display("FAIL rnd_flags0: got %b want %b", {overflow0, parity_err0, frame_err0}, {m_ovf[0], m_perr[0], m_ferr[0]}); end
      n_cmp++; if ({overflow1, parity_err1, frame_err1} !== {m_ovf[1], m_perr[1], m_ferr[1]}) begin n_bad++; $display("FAIL rnd_flags1: got %b want %b", {overflow1, parity_err1, frame_err1}, {m_ovf[1], m_perr[1], m_ferr[1]}); end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_good();
      test_parity();
      test_frame_err();
      test_overflow();
      test_mid_reset();
`ifdef PS2_KEY_EVENT_EN
      test_event();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4: FIFO depth 2**DEPTH_LOG2 entries.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flops per pointer synchroniser, legal range 2..4.
REQ-003 SHALL have parameter CHECK_PARITY, default 1: 1 drops odd-parity-failing frames, 0 ignores parity.
REQ-004 SHALL have port ps2_clk  input  1  write-side clock; ps2_data sampled on its rising edge.
REQ-005 SHALL have port sys_clk  input  1  read-side clock.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low; applied synchronously in both the ps2_clk and sys_clk domains.
REQ-007 SHALL have port ps2_data  input  1  serial PS/2 data line.
REQ-008 SHALL have port rd_en  input  1  pop request, sys_clk domain.
REQ-009 SHALL have port rd_valid  output  1  FIFO non-empty, sys_clk domain.
REQ-010 SHALL have port rd_data  output  OUT_W  head entry, show-ahead; OUT_W=10 with PS2_KEY_EVENT_EN, else 8.
REQ-011 SHALL have ports overflow, parity_err, frame_err  output  1 each  sticky error flags, ps2_clk domain.

Function
REQ-012 Frame FSM states: IDLE, DATA, PARITY, STOP; one transition per rising ps2_clk edge.
REQ-013 IDLE: ps2_data=0 (start bit) -> DATA with bit count 0; ps2_data=1 -> stay IDLE.
REQ-014 DATA: shift data bits LSB first; after 8th bit -> PARITY.
REQ-015 PARITY: capture bit -> STOP; parity OK when the 8 data bits plus parity bit contain an odd number of ones.
REQ-016 STOP: ps2_data=1 and (parity OK or CHECK_PARITY=0) -> commit byte; otherwise drop byte; always -> IDLE.
REQ-017 Bad stop bit: frame_err <= 1; parity failure (CHECK_PARITY=1) with good stop: parity_err <= 1.
REQ-018 Committed entry written to FIFO on the STOP edge when not full; when full, entry discarded and overflow <= 1, write pointer unchanged.
REQ-019 FIFO asynchronous: binary+Gray pointers; write Gray pointer synchronised into sys_clk, read Gray pointer into ps2_clk, each through SYNC_STAGES flops.
REQ-020 Full: write Gray pointer equals read-synced Gray with two MSBs inverted; empty: read Gray pointer equals write-synced Gray.
REQ-021 rd_valid rises no later than SYNC_STAGES+1 sys_clk edges after the committing ps2_clk edge.
REQ-022 Pop on sys_clk edge when rd_en=1 and rd_valid=1; rd_en while empty ignored, no pointer change.
REQ-023 rd_data = FIFO[read pointer], combinational from storage, stable while rd_valid=1 and no pop.
REQ-024 Pointers wrap modulo 2**(DEPTH_LOG2+1); exactly 2**DEPTH_LOG2 entries storable.
REQ-025 Simultaneous push and pop on respective clocks always legal; no entry lost or duplicated.

Reset
REQ-026 rst_n=0 at a ps2_clk edge: FSM IDLE, bit count 0, write pointers 0, overflow/parity_err/frame_err 0, prefix flags 0.
REQ-027 rst_n=0 at a sys_clk edge: read pointers 0, synchroniser flops 0, rd_valid 0.
REQ-028 Reset mid-frame abandons the partial frame; no write results from it.
REQ-029 Error flags clear only by reset.

Configuration
REQ-030 Macro PS2_KEY_EVENT_EN defined: byte 0xE0 sets ext flag, 0xF0 sets brk flag, neither pushed; next other byte pushes {ext, brk, byte}, then clears both flags; dropped frame clears both flags.
REQ-031 PS2_KEY_EVENT_EN undefined: every committed byte pushed raw, OUT_W=8, no prefix logic.

Structure
REQ-032 Shared package ps2_pkg SHALL hold FSM state enum, PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0, frame bit counts.
REQ-033 Async FIFO SHALL be sub-module ps2_afifo (parameters DEPTH_LOG2, SYNC_STAGES, width); frame FSM and prefix logic live in ps2_rx_fifo.

Verification
REQ-034 Frame 0x1C, parity 0, stop 1 -> rd_valid within 3 sys_clk, rd_data=0x1C (0x01C event mode), all error flags 0.
REQ-035 Frame 0x1C, parity 1 -> no entry, parity_err=1; repeat with CHECK_PARITY=0 -> entry 0x1C, parity_err 0.
REQ-036 Frame 0x1C, stop bit 0 -> no entry, frame_err=1; next good frame 0x32 -> rd_data=0x32.
REQ-037 17 good frames 0x00..0x10, no reads, DEPTH_LOG2=4 -> overflow=1; 16 pops return 0x00..0x0F in order, then rd_valid=0.
REQ-038 Event mode: frames E0, F0, 75 -> one entry 0x375; following 1C -> entry 0x01C.
REQ-039 rst_n=0 after start+5 data bits, released -> frame 0x5A received, rd_data=0x5A, no flags set.
